huffman_stream: RTL and testbench



---
 rtl/huffman_pkg.sv | 18 +
 rtl/huffman_sort_unit.sv | 81 ++++++++
 rtl/huffman_stream.sv | 214 +++++++++++++++++++++
 tb/tb_huffman_stream.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman code generator: controller states and
// the bus packing helper used by the top level and the sort unit.
package huffman_pkg;

  typedef enum logic [2:0] {
    S_COUNT,
    S_LOAD,
    S_SORT,
    S_MERGE,
    S_DONE
  } state_e;

  // Low bit of entry k in a bus of w-bit entries packed from bit 0 upwards.
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/huffman_sort_unit.sv
// Stable descending insertion sort sequencer over the live part of the node
// list. It owns the loop indices and issues one compare per cycle; the owner
// of the list performs the swap of entries swap_idx-1 and swap_idx.
module huffman_sort_unit
  import huffman_pkg::*;
#(
  parameter int NSYM  = 6,
  parameter int CNT_W = 8,
  parameter int IDX_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IDX_W-1:0]      len,
  input  logic [NSYM*CNT_W-1:0] weight_flat,
  output logic                  swap_en,
  output logic [IDX_W-1:0]      swap_idx,
  output logic                  done
);

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  logic             active_q, active_d;
  logic [IDX_W-1:0] i_q, i_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [CNT_W-1:0] w [NSYM];

  // Unpack the weight bus for indexed compares.
  always_comb begin
    for (int k = 0; k < NSYM; k++) begin
      w[k] = weight_flat[slice_lo(k, CNT_W) +: CNT_W];
    end
  end

  // One compare per cycle; swapping only on strictly greater keeps ties in order.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    active_d = active_q;
    i_d      = i_q;
    j_d      = j_q;
    swap_en  = 1'b0;
    done     = 1'b0;
    swap_idx = j_q;
    if (start) begin
      active_d = 1'b1;
      i_d      = IDX_ONE;
      j_d      = IDX_ONE;
    end else if (active_q) begin
      if (i_q >= len) begin
        done     = 1'b1;
        active_d = 1'b0;
      end else if (w[j_q] > w[j_q - IDX_ONE]) begin
        swap_en = 1'b1;
        if (j_q == IDX_ONE) begin
          i_d = i_q + IDX_ONE;
          j_d = i_q + IDX_ONE;
        end else begin
          j_d = j_q - IDX_ONE;
        end
      end else begin
        i_d = i_q + IDX_ONE;
        j_d = i_q + IDX_ONE;
      end
    end
  end

  // Index and activity registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is written with <= so all flops update from pre-edge values.
    if (reset) begin
      active_q <= 1'b0;
      i_q      <= '0;
      j_q      <= '0;
    end else begin
      active_q <= active_d;
      i_q      <= i_d;
      j_q      <= j_d;
    end
  end

endmodule

// File: rtl/huffman_stream.sv
// Frame-repeating Huffman code generator: counts NSAMP symbols, publishes the
// counts, then merges the two lightest list entries until one remains,
// writing code bits LSB-first per symbol.
module huffman_stream
  import huffman_pkg::*;
#(
  parameter int NSYM   = 6,
  parameter int DATA_W = 8,
  parameter int NSAMP  = 100,
  parameter int CNT_W  = 8,
  parameter int CODE_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   gray_valid,
  input  logic [DATA_W-1:0]      gray_data,
  output logic                   gray_ready,
  output logic                   busy,
  output logic                   cnt_valid,
  output logic [NSYM*CNT_W-1:0]  cnt_bus,
  output logic                   code_valid,
  output logic [NSYM*CODE_W-1:0] hc_bus,
  output logic [NSYM*CODE_W-1:0] m_bus,
  output logic                   sym_err
);

  localparam int IDX_W = $clog2(NSYM + 1);
  localparam int POS_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_TWO = IDX_W'(2);

  typedef struct packed {
    logic [CNT_W-1:0] weight;
    logic [NSYM-1:0]  set;
  } node_t;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       acc_q  [NSYM], acc_d  [NSYM];
  node_t                  list_q [NSYM], list_d [NSYM];
  logic [CODE_W-1:0]      code_q [NSYM], code_d [NSYM];
  logic [CODE_W-1:0]      mask_q [NSYM], mask_d [NSYM];
  logic [POS_W-1:0]       pos_q  [NSYM], pos_d  [NSYM];
  logic [CNT_W-1:0]       samp_q, samp_d;
  logic [IDX_W-1:0]       len_q, len_d;
  logic                   sym_err_q, sym_err_d;
  logic                   cnt_valid_q, cnt_valid_d;
  logic                   code_valid_q, code_valid_d;
  logic [NSYM*CNT_W-1:0]  cnt_bus_q, cnt_bus_d;
  logic [NSYM*CODE_W-1:0] hc_bus_q, hc_bus_d;
  logic [NSYM*CODE_W-1:0] m_bus_q, m_bus_d;

  logic                   accept, in_range;
  node_t                  node_a, node_b;
  logic [NSYM*CNT_W-1:0]  weight_flat;
  logic                   sort_start, swap_en, sort_done;
  logic [IDX_W-1:0]       swap_idx;

  assign gray_ready = (state_q == S_COUNT);
  assign busy       = (state_q == S_SORT) || (state_q == S_MERGE) || (state_q == S_DONE);
  assign accept     = gray_valid && gray_ready;
  assign sort_start = (state_q == S_LOAD) || ((state_q == S_MERGE) && (len_q != IDX_TWO));

  assign cnt_valid  = cnt_valid_q;
  assign cnt_bus    = cnt_bus_q;
  assign code_valid = code_valid_q;
  assign hc_bus     = hc_bus_q;
  assign m_bus      = m_bus_q;
  assign sym_err    = sym_err_q;

  // Flatten node weights for the sort sequencer.
  always_comb begin
    for (int k = 0; k < NSYM; k++) begin
      weight_flat[slice_lo(k, CNT_W) +: CNT_W] = list_q[k].weight;
    end
  end

  huffman_sort_unit #(
    .NSYM  (NSYM),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) u_sort (
    .clk         (clk),
    .reset       (reset),
    .start       (sort_start),
    .len         (len_q),
    .weight_flat (weight_flat),
    .swap_en     (swap_en),
    .swap_idx    (swap_idx),
    .done        (sort_done)
  );

  // Controller: counting, list load, sort/merge loop and code publication.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    list_d       = list_q;
    code_d       = code_q;
    mask_d       = mask_q;
    pos_d        = pos_q;
    samp_d       = samp_q;
    len_d        = len_q;
    sym_err_d    = sym_err_q;
    cnt_bus_d    = cnt_bus_q;
    hc_bus_d     = hc_bus_q;
    m_bus_d      = m_bus_q;
    cnt_valid_d  = 1'b0;
    code_valid_d = 1'b0;
    in_range     = 1'b0;
    node_a       = '0;
    node_b       = '0;
    unique case (state_q)
      S_COUNT: begin
        if (accept) begin
          samp_d = samp_q + CNT_W'(1);
          for (int k = 0; k < NSYM; k++) begin
            if (gray_data == DATA_W'(k + 1)) begin
              acc_d[k] = acc_q[k] + CNT_W'(1);
              in_range = 1'b1;
            end
          end
          // The error flag belongs to the frame: the first sample restarts it.
          sym_err_d = ((samp_q == '0) ? 1'b0 : sym_err_q) | ~in_range;
          if (samp_q == CNT_W'(NSAMP - 1)) state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_valid_d = 1'b1;
        for (int k = 0; k < NSYM; k++) begin
          cnt_bus_d[slice_lo(k, CNT_W) +: CNT_W] = acc_q[k];
          list_d[k].weight = acc_q[k];
          list_d[k].set    = '0;
          list_d[k].set[k] = 1'b1;
          code_d[k]        = '0;
          mask_d[k]        = '0;
          pos_d[k]         = '0;
        end
        len_d   = IDX_W'(NSYM);
        state_d = S_SORT;
      end
      S_SORT: begin
        if (swap_en) begin
          list_d[swap_idx]           = list_q[swap_idx - IDX_ONE];
          list_d[swap_idx - IDX_ONE] = list_q[swap_idx];
        end
        if (sort_done) state_d = S_MERGE;
      end
      S_MERGE: begin
        node_a = list_q[len_q - IDX_ONE];
        node_b = list_q[len_q - IDX_TWO];
        for (int k = 0; k < NSYM; k++) begin
          if (node_a.set[k] || node_b.set[k]) begin
            code_d[k][pos_q[k]] = node_a.set[k];
            mask_d[k][pos_q[k]] = 1'b1;
            pos_d[k]            = pos_q[k] + POS_W'(1);
          end
        end
        list_d[len_q - IDX_TWO].weight = node_a.weight + node_b.weight;
        list_d[len_q - IDX_TWO].set    = node_a.set | node_b.set;
        len_d   = len_q - IDX_ONE;
        state_d = (len_q == IDX_TWO) ? S_DONE : S_SORT;
      end
      S_DONE: begin
        code_valid_d = 1'b1;
        for (int k = 0; k < NSYM; k++) begin
          hc_bus_d[slice_lo(k, CODE_W) +: CODE_W] = code_q[k];
          m_bus_d[slice_lo(k, CODE_W) +: CODE_W]  = mask_q[k];
          acc_d[k] = '0;
        end
        samp_d  = '0;
        state_d = S_COUNT;
      end
      default: state_d = S_COUNT;
    endcase
  end

  // State, working list and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_COUNT;
      samp_q       <= '0;
      len_q        <= '0;
      sym_err_q    <= 1'b0;
      cnt_valid_q  <= 1'b0;
      code_valid_q <= 1'b0;
      cnt_bus_q    <= '0;
      hc_bus_q     <= '0;
      m_bus_q      <= '0;
      // NOTE: these arrays are flop-based and few, so they are cleared like any other state.
      for (int k = 0; k < NSYM; k++) begin
        acc_q[k]  <= '0;
        list_q[k] <= '0;
        code_q[k] <= '0;
        mask_q[k] <= '0;
        pos_q[k]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      samp_q       <= samp_d;
      len_q        <= len_d;
      sym_err_q    <= sym_err_d;
      cnt_valid_q  <= cnt_valid_d;
      code_valid_q <= code_valid_d;
      cnt_bus_q    <= cnt_bus_d;
      hc_bus_q     <= hc_bus_d;
      m_bus_q      <= m_bus_d;
      acc_q        <= acc_d;
      list_q       <= list_d;
      code_q       <= code_d;
      mask_q       <= mask_d;
      pos_q        <= pos_d;
    end
  end

endmodule

// File: tb/tb_huffman_stream.sv
// Directed bench for huffman_stream with default parameters.
module tb_huffman_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        gray_valid;
  logic [7:0]  gray_data;
  logic        gray_ready;
  logic        busy;
  logic        cnt_valid;
  logic [47:0] cnt_bus;
  logic        code_valid;
  logic [47:0] hc_bus;
  logic [47:0] m_bus;
  logic        sym_err;

  int n_checks = 0;
  int n_fail   = 0;

  huffman_stream dut (
    .clk        (clk),
    .reset      (reset),
    .gray_valid (gray_valid),
    .gray_data  (gray_data),
    .gray_ready (gray_ready),
    .busy       (busy),
    .cnt_valid  (cnt_valid),
    .cnt_bus    (cnt_bus),
    .code_valid (code_valid),
    .hc_bus     (hc_bus),
    .m_bus      (m_bus),
    .sym_err    (sym_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Symbol 1 lands in the low byte.
  function automatic logic [47:0] pack6(input logic [7:0] s1, s2, s3, s4, s5, s6);
    return {s6, s5, s4, s3, s2, s1};
  endfunction

  // Sends one frame (counts per symbol plus nbad out-of-range values, 100 total),
  // then stops at the LOAD cycle, optionally keeping gray_valid high.
  task automatic run_frame(input int c1, c2, c3, c4, c5, c6, input int nbad, input bit hold);
    logic [7:0] q[$];
    int cnt[6];
    cnt = '{c1, c2, c3, c4, c5, c6};
    for (int s = 0; s < 6; s++)
      for (int r = 0; r < cnt[s]; r++) q.push_back(8'(s + 1));
    for (int b = 0; b < nbad; b++) q.insert(b * 9, (b % 2 == 0) ? 8'd0 : 8'd7);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      if (i == q.size() - 1) check("ready_before_last", gray_ready, 1);
      gray_valid = 1'b1;
      gray_data  = q[i];
      @(posedge clk);
      if (i == 0) begin
        #1;
        check("sym_err_first", sym_err, (q[0] == 8'd0 || q[0] > 8'd6));
      end
    end
    @(negedge clk);
    gray_valid = hold;
    gray_data  = 8'd2;
    check("ready_load", gray_ready, 0);
    check("busy_load", busy, 0);
  endtask

  task automatic wait_results(input logic [47:0] exp_cnt, exp_hc, exp_m, input logic exp_err);
    bit found;
    bit ready_seen;
    int lat;
    found = 0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clk);
      if (cnt_valid) found = 1;
    end
    check("cnt_valid_pulse", found, 1);
    check("cnt_bus", cnt_bus, exp_cnt);
    check("busy_sort", busy, 1);
    found = 0;
    ready_seen = 0;
    lat = 0;
    while (!found && lat < 300) begin
      @(negedge clk);
      lat++;
      if (code_valid) found = 1;
      else if (gray_ready) ready_seen = 1;
    end
    gray_valid = 1'b0;
    check("code_valid_seen", found, 1);
    check("latency_bound", (lat <= 184), 1);
    check("ready_low_while_busy", ready_seen, 0);
    check("hc_bus", hc_bus, exp_hc);
    check("m_bus", m_bus, exp_m);
    check("sym_err_end", sym_err, exp_err);
    check("busy_after", busy, 0);
    check("ready_after", gray_ready, 1);
    @(negedge clk);
    check("code_valid_single", code_valid, 0);
    check("cnt_bus_hold", cnt_bus, exp_cnt);
  endtask

  initial begin
    bit found;
    int pulses;
    reset      = 1'b1;
    gray_valid = 1'b0;
    gray_data  = 8'd0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", gray_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_cnt_valid", cnt_valid, 0);
    check("rst_code_valid", code_valid, 0);
    check("rst_cnt_bus", cnt_bus, 0);
    check("rst_hc", hc_bus, 0);
    check("rst_m", m_bus, 0);
    check("rst_sym_err", sym_err, 0);
    reset = 1'b0;

    // Skewed distribution.
    run_frame(40, 30, 15, 10, 4, 1, 0, 1'b0);
    wait_results(pack6(40, 30, 15, 10, 4, 1),
                 pack6(8'h01, 8'h00, 8'h02, 8'h06, 8'h0E, 8'h0F),
                 pack6(8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F), 1'b0);

    // Single symbol, gray_valid held high (data 2) while busy.
    run_frame(100, 0, 0, 0, 0, 0, 0, 1'b1);
    wait_results(pack6(100, 0, 0, 0, 0, 0),
                 pack6(8'h00, 8'h02, 8'h06, 8'h0E, 8'h1E, 8'h1F),
                 pack6(8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F), 1'b0);

    // Ten out-of-range samples (0 and 7) mixed in; ties resolved by stable sort.
    run_frame(30, 25, 15, 10, 6, 4, 10, 1'b0);
    wait_results(pack6(30, 25, 15, 10, 6, 4),
                 pack6(8'h00, 8'h01, 8'h03, 8'h04, 8'h0A, 8'h0B),
                 pack6(8'h03, 8'h03, 8'h03, 8'h07, 8'h0F, 8'h0F), 1'b1);

    // Back-to-back clean frame: error flag restarts, codes recomputed.
    run_frame(40, 30, 15, 10, 4, 1, 0, 1'b0);
    wait_results(pack6(40, 30, 15, 10, 4, 1),
                 pack6(8'h01, 8'h00, 8'h02, 8'h06, 8'h0E, 8'h0F),
                 pack6(8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F), 1'b0);

    // Reset while sorting.
    run_frame(30, 25, 15, 10, 6, 4, 10, 1'b0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (busy) found = 1;
    end
    check("busy_before_abort", found, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_ready", gray_ready, 1);
    check("abort_cnt_bus", cnt_bus, 0);
    check("abort_hc", hc_bus, 0);
    check("abort_m", m_bus, 0);
    check("abort_sym_err", sym_err, 0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (code_valid || cnt_valid) pulses++;
    end
    check("abort_no_pulses", pulses, 0);

    run_frame(100, 0, 0, 0, 0, 0, 0, 1'b0);
    wait_results(pack6(100, 0, 0, 0, 0, 0),
                 pack6(8'h00, 8'h02, 8'h06, 8'h0E, 8'h1E, 8'h1F),
                 pack6(8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
